// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clkdiv_pkg
//  Description : Shared constants for the programmable clock divider:
//                the minimum legal divisor and the reset divisors for the
//                three standard channels (50 MHz system clock).
//  Revision    : 1.0  initial release
// ============================================================================
package clkdiv_pkg;

    // Smallest divisor that still yields a square wave (1 high, 1 low).
    localparam int DIV_MIN         = 2;

    // Reset divisors: ch0 = 1 Hz, ch1 = 20 Hz, ch2 = 500 Hz at 50 MHz.
    localparam int DEFAULT_DIV_CH0 = 50000000;
    localparam int DEFAULT_DIV_CH1 = 2500000;
    localparam int DEFAULT_DIV_CH2 = 100000;

endpackage : clkdiv_pkg
`default_nettype wire

// File: rtl/clkdiv_channel.sv
`default_nettype none
// ============================================================================
//  Module      : clkdiv_channel
//  Description : One divider channel. Holds the active divisor N, a shadow
//                divisor with a pending flag, and a counter running 0..N-1.
//                Produces a registered square wave (floor(N/2) cycles high)
//                and a one-cycle tick coincident with each rising edge.
//  Ports       : clock    - system clock, rising edge
//                reset_n  - asynchronous active-low reset
//                enable   - run enable; low holds counter and clk_out
//                sync     - restart counter, apply pending divisor now
//                wr       - decoded write strobe for this channel
//                wr_data  - clamped divisor value to write
//                clk_out  - registered square-wave output
//                tick     - registered one-cycle pulse per period
//                pending  - shadow divisor waiting for a period boundary
//  Revision    : 1.0  initial release
// ============================================================================
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int               DIV_W     = 32,
    parameter logic [DIV_W-1:0] RESET_DIV = DIV_W'(DIV_MIN)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_data,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    localparam logic [DIV_W-1:0] C_ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_active;
    logic [DIV_W-1:0] r_shadow;
    logic             r_clk;
    logic             r_tick;
    logic             r_pending;

    logic             w_boundary;
    logic             w_half_end;
    logic             w_step;

    // Last count of the period, and last count of the high phase (H-1).
    assign w_boundary = (r_cnt == (r_active - C_ONE));
    assign w_half_end = (r_cnt == ((r_active >> 1) - C_ONE));
    // A boundary only happens on an edge where the channel actually counts.
    assign w_step     = enable && w_boundary;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_active  <= RESET_DIV;
            r_shadow  <= RESET_DIV;
            r_clk     <= 1'b0;
            r_tick    <= 1'b0;
            r_pending <= 1'b0;
        end else if (sync) begin
            // Restart regardless of enable; a same-cycle write wins over an
            // older pending shadow and is applied at once.
            r_cnt     <= '0;
            r_clk     <= 1'b0;
            r_tick    <= 1'b0;
            r_pending <= 1'b0;
            if (wr) begin
                r_active <= wr_data;
                r_shadow <= wr_data;
            end else if (r_pending) begin
                r_active <= r_shadow;
            end
        end else begin
            if (enable) begin
                r_tick <= w_boundary;
                if (w_boundary) begin
                    r_cnt <= '0;
                    r_clk <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + C_ONE;
                    if (w_half_end) begin
                        r_clk <= 1'b0;
                    end
                end
            end else begin
                r_tick <= 1'b0;
            end

            // Only a shadow that was pending before this edge is applied;
            // a write landing on the boundary waits for the next one.
            if (w_step && r_pending) begin
                r_active <= r_shadow;
            end

            if (wr) begin
                r_shadow  <= wr_data;
                r_pending <= 1'b1;
            end else if (w_step) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign clk_out = r_clk;
    assign tick    = r_tick;
    assign pending = r_pending;

endmodule : clkdiv_channel
`default_nettype wire

// File: rtl/prog_clock_divider.sv
`default_nettype none
// ============================================================================
//  Module      : prog_clock_divider
//  Description : NUM_CH independent programmable clock dividers sharing one
//                system clock. This level only decodes divisor writes,
//                clamps the written divisor to DIV_MIN and fans out sync.
//  Ports       : clock    - system clock, rising edge
//                reset_n  - asynchronous active-low reset
//                enable   - per-channel run enable
//                sync     - one-cycle pulse, phase-aligns all channels
//                div_wr   - divisor write strobe
//                div_sel  - channel index for div_wr (out of range ignored)
//                div_data - new divisor (full period in clock cycles)
//                clk_out  - per-channel square-wave outputs
//                tick     - per-channel one-cycle period pulse
//                pending  - per-channel written divisor not yet applied
//  Revision    : 1.0  initial release
// ============================================================================
module prog_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int                      NUM_CH      = 3,
    parameter int                      DIV_W       = 32,
    parameter logic [NUM_CH*DIV_W-1:0] DEFAULT_DIV = {DIV_W'(DEFAULT_DIV_CH2),
                                                      DIV_W'(DEFAULT_DIV_CH1),
                                                      DIV_W'(DEFAULT_DIV_CH0)}
) (
    input  logic                                          clock,
    input  logic                                          reset_n,
    input  logic [NUM_CH-1:0]                             enable,
    input  logic                                          sync,
    input  logic                                          div_wr,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] div_sel,
    input  logic [DIV_W-1:0]                              div_data,
    output logic [NUM_CH-1:0]                             clk_out,
    output logic [NUM_CH-1:0]                             tick,
    output logic [NUM_CH-1:0]                             pending
);

    localparam int               C_SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [DIV_W-1:0] C_DIV_MIN = DIV_W'(DIV_MIN);

    logic [DIV_W-1:0] w_wr_data;

    // Divisors below 2 cannot form a period with both phases present.
    assign w_wr_data = (div_data < C_DIV_MIN) ? C_DIV_MIN : div_data;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic w_wr;

        // An out-of-range div_sel matches no channel, so nothing changes.
        assign w_wr = div_wr && (div_sel == C_SEL_W'(i));

        clkdiv_channel #(
            .DIV_W     (DIV_W),
            .RESET_DIV (DEFAULT_DIV[i*DIV_W +: DIV_W])
        ) u_channel (
            .clock   (clock),
            .reset_n (reset_n),
            .enable  (enable[i]),
            .sync    (sync),
            .wr      (w_wr),
            .wr_data (w_wr_data),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pending (pending[i])
        );
    end : g_ch

endmodule : prog_clock_divider
`default_nettype wire

// File: tb/tb_prog_clock_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_clock_divider
//  Description : Self-checking bench for prog_clock_divider. A per-channel
//                reference model tracks the position inside the current
//                period and derives clk_out / tick / pending from it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prog_clock_divider;

    localparam int NUM_CH = 3;
    localparam int DIV_W  = 16;

    logic              clock;
    logic              reset_n;
    logic [NUM_CH-1:0] enable;
    logic              sync;
    logic              div_wr;
    logic [1:0]        div_sel;
    logic [DIV_W-1:0]  div_data;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pending;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state per channel.
    int def_div[NUM_CH] = '{2, 3, 6};
    int m_n    [NUM_CH];
    int m_sh   [NUM_CH];
    int m_pos  [NUM_CH];   // cycles elapsed in the current period
    bit m_pend [NUM_CH];
    bit m_run  [NUM_CH];   // a full period has completed since restart
    bit m_tick [NUM_CH];

    prog_clock_divider #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV ({16'd6, 16'd3, 16'd2})
    ) u_dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .enable   (enable),
        .sync     (sync),
        .div_wr   (div_wr),
        .div_sel  (div_sel),
        .div_data (div_data),
        .clk_out  (clk_out),
        .tick     (tick),
        .pending  (pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_n[c]    = def_div[c];
            m_sh[c]   = def_div[c];
            m_pos[c]  = 0;
            m_pend[c] = 1'b0;
            m_run[c]  = 1'b0;
            m_tick[c] = 1'b0;
        end
    endtask

    // Advance the model by one rising edge using the inputs held there.
    task automatic model_edge();
        for (int c = 0; c < NUM_CH; c++) begin
            bit hit;
            int d;
            hit = div_wr && (int'(div_sel) == c);
            d   = (int'(div_data) < 2) ? 2 : int'(div_data);
            if (sync) begin
                m_pos[c]  = 0;
                m_run[c]  = 1'b0;
                m_tick[c] = 1'b0;
                if (hit) begin
                    m_n[c]  = d;
                    m_sh[c] = d;
                end else if (m_pend[c]) begin
                    m_n[c] = m_sh[c];
                end
                m_pend[c] = 1'b0;
            end else begin
                if (enable[c]) begin
                    if (m_pos[c] == m_n[c] - 1) begin
                        m_tick[c] = 1'b1;
                        m_pos[c]  = 0;
                        m_run[c]  = 1'b1;
                        if (m_pend[c]) begin
                            m_n[c]    = m_sh[c];
                            m_pend[c] = 1'b0;
                        end
                    end else begin
                        m_tick[c] = 1'b0;
                        m_pos[c]++;
                    end
                end else begin
                    m_tick[c] = 1'b0;
                end
                if (hit) begin
                    m_sh[c]   = d;
                    m_pend[c] = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < NUM_CH; c++) begin
            bit exp_clk;
            // High for the first floor(N/2) cycles of every completed period.
            exp_clk = m_run[c] && (m_pos[c] < m_n[c] / 2);
            check_val($sformatf("clk_out[%0d]", c), 32'(clk_out[c]), 32'(exp_clk));
            check_val($sformatf("tick[%0d]", c),    32'(tick[c]),    32'(m_tick[c]));
            check_val($sformatf("pending[%0d]", c), 32'(pending[c]), 32'(m_pend[c]));
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        compare_all();
    endtask

    task automatic run(input int cycles);
        for (int k = 0; k < cycles; k++) step();
    endtask

    task automatic write_div(input logic [1:0] sel, input logic [DIV_W-1:0] data);
        div_wr   = 1'b1;
        div_sel  = sel;
        div_data = data;
        step();
        div_wr   = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        enable   = '1;
        sync     = 1'b0;
        div_wr   = 1'b0;
        div_sel  = '0;
        div_data = '0;
        model_reset();

        // Reset state.
        repeat (2) @(negedge clock);
        check_val("reset clk_out", 32'(clk_out), 32'd0);
        check_val("reset tick",    32'(tick),    32'd0);
        check_val("reset pending", 32'(pending), 32'd0);
        reset_n = 1'b1;

        // Default divisors 2 / 3 / 6 free-running.
        run(20);

        // ch2: reprogram to 4 mid-period.
        run(2);
        write_div(2'd2, 16'd4);
        check_val("ch2 pending after write", 32'(pending[2]), 32'd1);
        run(20);

        // ch0: zero clamps to 2; out-of-range select changes nothing.
        write_div(2'd0, 16'd0);
        run(8);
        write_div(2'd3, 16'd7);
        check_val("sel3 pending", 32'(pending), 32'd0);
        run(10);

        // ch1 paused for five cycles mid-period.
        run(1);
        enable[1] = 1'b0;
        run(5);
        enable[1] = 1'b1;
        run(12);

        // Drift ch0 out of phase, queue a divisor on ch1, then sync.
        enable[0] = 1'b0;
        run(1);
        enable[0] = 1'b1;
        write_div(2'd1, 16'd5);
        run(1);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check_val("sync clk_out", 32'(clk_out), 32'd0);
        run(14);

        // sync with a simultaneous write applies immediately.
        sync = 1'b1;
        write_div(2'd2, 16'd3);
        sync = 1'b0;
        check_val("sync+wr pending", 32'(pending), 32'd0);
        run(10);

        // Asynchronous reset between edges with a write pending.
        write_div(2'd2, 16'd5);
        #2 reset_n = 1'b0;
        #1;
        check_val("async rst clk_out", 32'(clk_out), 32'd0);
        check_val("async rst tick",    32'(tick),    32'd0);
        check_val("async rst pending", 32'(pending), 32'd0);
        model_reset();
        #1 reset_n = 1'b1;
        run(14);

        // Randomized traffic.
        for (int k = 0; k < 500; k++) begin
            enable   = ($urandom_range(9, 0) == 0) ? NUM_CH'($urandom) : '1;
            div_wr   = ($urandom_range(7, 0) == 0);
            div_sel  = 2'($urandom_range(3, 0));
            div_data = DIV_W'($urandom_range(9, 0));
            sync     = ($urandom_range(39, 0) == 0);
            step();
        end
        div_wr = 1'b0;
        sync   = 1'b0;
        enable = '1;
        run(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_prog_clock_divider
`default_nettype wire

// File: doc/prog_clock_divider.md
PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, meaning the number of independent divider channels.
REQ-002 SHALL have parameter DIV_W, default 32, meaning the divisor and counter width.
REQ-003 SHALL have parameter DEFAULT_DIV (NUM_CH*DIV_W bits), default {100000, 2500000, 50000000} for ch2..ch0, meaning the reset divisors (500 Hz, 20 Hz and 1 Hz at 50 MHz).
REQ-004 SHALL have port: clock  in  1  single system clock, all logic on its rising edge.
REQ-005 SHALL have port: reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: enable  in  NUM_CH  per-channel run enable.
REQ-007 SHALL have port: sync  in  1  one-cycle pulse that restarts all channels phase-aligned.
REQ-008 SHALL have port: div_wr  in  1  one-cycle divisor write strobe.
REQ-009 SHALL have port: div_sel  in  clog2(NUM_CH)  target channel index for div_wr.
REQ-010 SHALL have port: div_data  in  DIV_W  new divisor N, the full output period in clock cycles.
REQ-011 SHALL have port: clk_out  out  NUM_CH  registered square-wave outputs.
REQ-012 SHALL have port: tick  out  NUM_CH  registered one-cycle pulse per period.
REQ-013 SHALL have port: pending  out  NUM_CH  high while a written divisor awaits application.

Function
REQ-014 Each channel SHALL hold an active divisor N, a shadow divisor, and a counter cnt running 0..N-1.
REQ-015 When enabled, each edge SHALL update cnt <= (cnt==N-1) ? 0 : cnt+1.
REQ-016 When enabled, each edge SHALL update tick <= (cnt==N-1), giving exactly one high cycle every N cycles.
REQ-017 With H = floor(N/2), clk_out SHALL be set on the edge where cnt==N-1 and cleared on the edge where cnt==H-1, giving H cycles high and N-H cycles low per period.
REQ-018 The clk_out rising edge SHALL coincide with tick assertion.
REQ-019 When enable[i]=0, cnt[i] and clk_out[i] SHALL hold and tick[i] SHALL be 0; counting SHALL resume from the held cnt.
REQ-020 div_wr SHALL write div_data to the shadow of channel div_sel and set pending[div_sel] on that edge.
REQ-021 div_data < 2 SHALL be clamped to 2.
REQ-022 div_sel >= NUM_CH SHALL be ignored, with no state change.
REQ-023 A pending shadow SHALL become active N on a boundary edge (cnt==N-1) only if pending was already set before that edge; pending SHALL clear on that same edge.
REQ-024 A write coinciding with a boundary edge SHALL apply at the following boundary.
REQ-025 A repeated write while pending SHALL overwrite the shadow, and only the last value SHALL apply.
REQ-026 sync SHALL set, on all channels regardless of enable: cnt<=0, clk_out<=0, tick<=0, active N<=shadow where pending, and pending<=0.
REQ-027 div_wr in the same cycle as sync SHALL apply div_data immediately, with pending ending at 0.
REQ-028 sync SHALL take priority over channel enable and over boundary logic.
REQ-029 No output SHALL be combinational from any input; output latency is one edge.

Reset
REQ-030 reset_n low SHALL asynchronously force: cnt=0, clk_out=0, tick=0, pending=0, active and shadow divisors = DEFAULT_DIV slices.
REQ-031 Reset asserted mid-period SHALL discard pending writes; after release, channels SHALL count from 0 on the first clock edge.

Structure
REQ-032 Shared package clkdiv_pkg SHALL hold DIV_MIN=2 and the default divisor constants.
REQ-033 Sub-module clkdiv_channel (counter, shadow, pending, outputs) SHALL be instantiated NUM_CH times by generate.
REQ-034 Top level SHALL contain only write decode, clamping and sync fan-out.

Verification
REQ-035 DEFAULT_DIV={6,3,2}, all enabled, after reset: ch0 clk_out alternates 1/1; ch1 high 1, low 2; ch2 high 3, low 3; each tick once per period, coincident with clk_out rise.
REQ-036 ch2 N=6: write 4 mid-period -> pending=1, current period completes at 6, next periods at 4 cycles; pending clears on the boundary.
REQ-037 Write div_data=0 to ch0 -> period 2; write with div_sel=3 -> no channel changes.
REQ-038 enable[1]=0 for 5 cycles mid-period -> clk_out[1] frozen, tick[1]=0, period stretched by exactly 5.
REQ-039 Channels drifted out of phase plus pending write, then sync -> all clk_out=0 next edge, all rise together N cycles later, new divisor active.
REQ-040 reset_n pulsed low between clock edges mid-period -> outputs 0 immediately, pending dropped, DEFAULT_DIV restored.
